// File: rtl/mem_write_sched.sv
// rtl/mem_write_sched.sv - shared memory write port arbiter with DSP start sequencing
// Round-robin H/L write arbitration; start_req drains writes, pulses stb_start, then locks writes until run_done.
module mem_write_sched #(
  parameter int NPROC  = 3,
  parameter int NMEM   = 3,
  parameter int ADDRW  = 16,
  parameter int DATAW  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             h_valid,
  output logic             h_ready,
  input  logic [2:0]       h_proc_sel,
  input  logic [2:0]       h_mem_sel,
  input  logic [ADDRW-1:0] h_addr,
  input  logic [DATAW-1:0] h_data,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [2:0]       l_proc_sel,
  input  logic [2:0]       l_mem_sel,
  input  logic [ADDRW-1:0] l_addr,
  input  logic [DATAW-1:0] l_data,
  input  logic             start_req,
  input  logic             run_done,
  output logic             mem_write_en,
  output logic [ADDRW-1:0] mem_write_addr,
  output logic [DATAW-1:0] mem_write_data,
  output logic [2:0]       proc_write_sel,
  output logic [2:0]       mem_write_sel,
  output logic             stb_start,
  output logic             busy,
  output logic             sel_err
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_STROBE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] data_q, data_d;
  logic [2:0]       proc_q, proc_d;
  logic [2:0]       msel_q, msel_d;
  logic             sel_err_q, sel_err_d;

  logic             grant_h, grant_l, accept, legal;
  logic [2:0]       a_proc, a_mem;
  logic [ADDRW-1:0] a_addr;
  logic [DATAW-1:0] a_data;

  // ptr_q: 0 favours H, 1 favours L on a conflict; ready is masked while reset is held
  always_comb begin
    grant_h = 1'b0;
    grant_l = 1'b0;
    if (state_q == S_IDLE && reset) begin
      if (h_valid && l_valid) begin
        grant_h = !ptr_q;
        grant_l = ptr_q;
      end else begin
        grant_h = h_valid;
        grant_l = l_valid;
      end
    end
  end

  assign h_ready = grant_h;
  assign l_ready = grant_l;
  assign accept  = grant_h | grant_l;
  assign a_proc  = grant_l ? l_proc_sel : h_proc_sel;
  assign a_mem   = grant_l ? l_mem_sel  : h_mem_sel;
  assign a_addr  = grant_l ? l_addr     : h_addr;
  assign a_data  = grant_l ? l_data     : h_data;
  assign legal   = (int'(a_proc) < NPROC) && (int'(a_mem) < NMEM);

  always_comb begin
    ptr_d     = ptr_q;
    en_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    proc_d    = proc_q;
    msel_d    = msel_q;
    sel_err_d = sel_err_q;
    if (grant_h) begin
      ptr_d = 1'b1;
    end else if (grant_l) begin
      ptr_d = 1'b0;
    end
    if (accept) begin
      if (legal) begin
        en_d   = 1'b1;
        addr_d = a_addr;
        data_d = a_data;
        proc_d = a_proc;
        msel_d = a_mem;
      end else begin
        sel_err_d = 1'b1;
      end
    end
  end

  // Settle count restarts whenever a write is still issuing, so it measures quiet cycles only
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (en_q) begin
          cnt_d = '0;
        end else if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_d >= SETTLE_C) state_d = S_STROBE;
      end
      S_STROBE: state_d = S_RUN;
      S_RUN: begin
        if (run_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      proc_q    <= '0;
      msel_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      proc_q    <= proc_d;
      msel_q    <= msel_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign mem_write_en   = en_q;
  assign mem_write_addr = addr_q;
  assign mem_write_data = data_q;
  assign proc_write_sel = proc_q;
  assign mem_write_sel  = msel_q;
  assign sel_err        = sel_err_q;
  assign stb_start      = (state_q == S_STROBE);
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_write_sched.sv
// tb/tb_mem_write_sched.sv - scoreboard bench for mem_write_sched
module tb_mem_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        h_valid, l_valid, h_ready, l_ready;
  logic [2:0]  h_proc_sel, h_mem_sel, l_proc_sel, l_mem_sel;
  logic [15:0] h_addr, l_addr;
  logic [31:0] h_data, l_data;
  logic        start_req, run_done;
  logic        mem_write_en, stb_start, busy, sel_err;
  logic [15:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic [2:0]  proc_write_sel, mem_write_sel;

  mem_write_sched dut (
    .clk(clk), .reset(reset),
    .h_valid(h_valid), .h_ready(h_ready), .h_proc_sel(h_proc_sel), .h_mem_sel(h_mem_sel),
    .h_addr(h_addr), .h_data(h_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_proc_sel(l_proc_sel), .l_mem_sel(l_mem_sel),
    .l_addr(l_addr), .l_data(l_data),
    .start_req(start_req), .run_done(run_done),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .proc_write_sel(proc_write_sel), .mem_write_sel(mem_write_sel),
    .stb_start(stb_start), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        legal;
    logic [2:0]  p;
    logic [2:0]  m;
    logic [15:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic m_ptr = 1'b0;
  logic m_idle = 1'b1;
  logic m_sel_err = 1'b0;
  int   gh_cnt = 0;
  int   gl_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs already driven: checks readiness, then the registered write one cycle later
  task automatic tick();
    logic eh, el;
    exp_t e;
    #1;
    eh = m_idle && h_valid && (!l_valid || !m_ptr);
    el = m_idle && l_valid && (!h_valid || m_ptr);
    check_eq("h_ready", h_ready, eh);
    check_eq("l_ready", l_ready, el);
    gh_cnt += int'(h_ready);
    gl_cnt += int'(l_ready);
    if (eh) begin
      e.legal = (h_proc_sel < 3) && (h_mem_sel < 3);
      e.p = h_proc_sel; e.m = h_mem_sel; e.a = h_addr; e.d = h_data;
      exp_q.push_back(e);
      m_ptr = 1'b1;
    end else if (el) begin
      e.legal = (l_proc_sel < 3) && (l_mem_sel < 3);
      e.p = l_proc_sel; e.m = l_mem_sel; e.a = l_addr; e.d = l_data;
      exp_q.push_back(e);
      m_ptr = 1'b0;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("en", mem_write_en, e.legal);
      if (e.legal) begin
        check_eq("addr", mem_write_addr, e.a);
        check_eq("data", mem_write_data, e.d);
        check_eq("proc_sel", proc_write_sel, e.p);
        check_eq("mem_sel", mem_write_sel, e.m);
      end else begin
        m_sel_err = 1'b1;
      end
    end else begin
      check_eq("en_quiet", mem_write_en, 1'b0);
    end
    check_eq("sel_err", sel_err, m_sel_err);
  endtask

  initial begin
    reset = 1'b0;
    h_valid = 1'b1; l_valid = 1'b0;
    h_proc_sel = 3'd1; h_mem_sel = 3'd0; h_addr = 16'h0; h_data = 32'h0;
    l_proc_sel = 3'd2; l_mem_sel = 3'd1; l_addr = 16'h0; l_data = 32'h0;
    start_req = 1'b0; run_done = 1'b0;
    #3;
    check_eq("rst_h_ready", h_ready, 1'b0);
    check_eq("rst_en", mem_write_en, 1'b0);
    check_eq("rst_addr", mem_write_addr, 16'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_stb", stb_start, 1'b0);
    check_eq("rst_sel_err", sel_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    h_valid = 1'b0;
    tick();

    // Both requesters valid for 6 cycles: strict alternation starting with H
    h_valid = 1'b1; l_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      h_addr = 16'h100 + 16'(i); h_data = 32'hB000 + 32'(i);
      l_addr = 16'h200 + 16'(i); l_data = 32'hC000 + 32'(i);
      tick();
    end
    check_eq("h_grants", 64'(gh_cnt), 64'd3);
    check_eq("l_grants", 64'(gl_cnt), 64'd3);
    l_valid = 1'b0;

    // H alone, back-to-back writes
    h_proc_sel = 3'd1; h_mem_sel = 3'd0;
    for (int i = 0; i < 4; i++) begin
      h_addr = 16'(i); h_data = 32'hA0 + 32'(i);
      tick();
    end
    h_valid = 1'b0;
    tick();
    check_eq("addr_hold", mem_write_addr, 16'h3);

    // Write and start_req in the same cycle, then the drain/strobe sequence
    h_valid = 1'b1; h_addr = 16'h55; h_data = 32'h5555; start_req = 1'b1;
    tick();
    start_req = 1'b0;
    m_idle = 1'b0;
    h_addr = 16'h66; h_data = 32'h6666;
    for (int k = 1; k <= 5; k++) begin
      check_eq($sformatf("stb_t%0d", k), stb_start, k == 4);
      check_eq("busy_seq", busy, 1'b1);
      tick();
    end
    for (int k = 0; k < 10; k++) tick();
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
    m_idle = 1'b1;
    check_eq("busy_after_done", busy, 1'b0);
    tick();
    h_valid = 1'b0;
    tick();

    // Illegal selects are accepted, dropped, and latch sel_err
    h_valid = 1'b1; h_proc_sel = 3'd3; h_mem_sel = 3'd0; h_addr = 16'h77; h_data = 32'h7777;
    tick();
    h_proc_sel = 3'd0; h_mem_sel = 3'd2; h_addr = 16'h78; h_data = 32'h7878;
    tick();
    h_proc_sel = 3'd2; h_mem_sel = 3'd5; h_addr = 16'h79; h_data = 32'h7979;
    tick();
    h_valid = 1'b0;
    tick();
    check_eq("addr_after_illegal", mem_write_addr, 16'h78);

    // Reset in the middle of DRAIN
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    check_eq("busy_drain", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_busy", busy, 1'b0);
    check_eq("async_stb", stb_start, 1'b0);
    check_eq("async_en", mem_write_en, 1'b0);
    check_eq("async_addr", mem_write_addr, 16'h0);
    check_eq("async_sel_err", sel_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 1'b0; m_idle = 1'b1; m_sel_err = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      check_eq("no_stb_after_rst", stb_start, 1'b0);
      check_eq("idle_after_rst", busy, 1'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
